// File: rtl/ordenador_serial_pkg.sv
// ordenador_serial_pkg: shared constants and state encoding for the serial sorter
package ordenador_serial_pkg;

    localparam int N_LANES  = 8;
    localparam int N_PHASES = 8;

    localparam logic [2:0] LAST_IDX   = 3'(N_LANES - 1);
    localparam logic [2:0] LAST_PHASE = 3'(N_PHASES - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ordenador_serial_cs_min_max.sv
// cs_min_max: combinational unsigned compare-swap cell, equal words pass straight through
module cs_min_max #(
    parameter int Size = 8
) (
    output logic [Size-1:0] lo_o,
    output logic [Size-1:0] hi_o,
    input  logic [Size-1:0] a_i,
    input  logic [Size-1:0] b_i
);

    logic swap;

    assign swap = a_i > b_i;
    assign lo_o = swap ? b_i : a_i;
    assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/ordenador_serial.sv
// ordenador_serial: streaming 8-word sorter, odd-even transposition with 4 shared cells
module ordenador_serial
    import ordenador_serial_pkg::*;
#(
    parameter int Size = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [Size-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [Size-1:0] out_data,
    output logic            out_last,
    output logic            busy
);

    state_t          state;
    logic [2:0]      cnt;
    logic [2:0]      phase;
    logic [Size-1:0] r    [N_LANES];
    logic [Size-1:0] r_sw [N_LANES];
    logic [Size-1:0] lo   [4];
    logic [Size-1:0] hi   [4];

    // Even phases pair (2k,2k+1); odd phases pair (2k+1,2k+2), cell 3 idles on odd phases
    for (genvar k = 0; k < 4; k++) begin : g_cs
        localparam int OB = (k == 3) ? 7 : 2 * k + 2;
        cs_min_max #(.Size(Size)) u_cs (
            .lo_o (lo[k]),
            .hi_o (hi[k]),
            .a_i  (phase[0] ? r[2*k+1] : r[2*k]),
            .b_i  (phase[0] ? r[OB]    : r[2*k+1])
        );
    end

    // Lane file after the current phase's compare-swaps; untouched lanes hold
    always_comb begin
        for (int i = 0; i < N_LANES; i++) r_sw[i] = r[i];
        if (!phase[0]) begin
            for (int k = 0; k < 4; k++) begin
                r_sw[2*k]   = lo[k];
                r_sw[2*k+1] = hi[k];
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                r_sw[2*k+1] = lo[k];
                r_sw[2*k+2] = hi[k];
            end
        end
    end

    // FSM, counters, lane registers and registered handshake/status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD;
            cnt       <= '0;
            phase     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < N_LANES; i++) r[i] <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid) begin
                        r[cnt] <= in_data;
                        if (cnt == LAST_IDX) begin
                            cnt      <= '0;
                            state    <= ST_SORT;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                ST_SORT: begin
                    for (int i = 0; i < N_LANES; i++) r[i] <= r_sw[i];
                    if (phase == LAST_PHASE) begin
                        phase     <= '0;
                        state     <= ST_DRAIN;
                        out_valid <= 1'b1;
                    end else begin
                        phase <= phase + 3'd1;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (cnt == LAST_IDX) begin
                            cnt       <= '0;
                            state     <= ST_LOAD;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state     <= ST_LOAD;
                    cnt       <= '0;
                    phase     <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = out_valid ? r[cnt] : '0;
    assign out_last = out_valid && (cnt == LAST_IDX);

endmodule
